blink_tick_gen: RTL



---
 rtl/blink_tick_gen_if.sv | 14 +
 rtl/blink_tick_gen.sv | 70 +++++++
 2 files changed

// File: rtl/blink_tick_gen_if.sv
// blink_tick_gen_if: control/status bundle between the blink tick generator and its user
interface blink_tick_gen_if #(
    parameter int CNT_W = 24
);
    logic             en;
    logic             load;
    logic [CNT_W-1:0] half_period;
    logic             ready;
    logic             tick;
    logic             sq;
    logic [7:0]       toggles;
    modport master (output en, load, half_period, input ready, tick, sq, toggles);
    modport slave  (input en, load, half_period, output ready, tick, sq, toggles);
endinterface

// File: rtl/blink_tick_gen.sv
// blink_tick_gen: settle-gated programmable half-period tick and square-wave generator; BLINK_TICK_TOGGLE_CNT_EN enables the toggle counter
module blink_tick_gen #(
    parameter int CNT_W         = 24,
    parameter int SETTLE_CYCLES = 64,
    parameter int DEFAULT_HALF  = 2500000
) (
    input logic             clk,
    input logic             reset,
    blink_tick_gen_if.slave bus
);
    localparam int SW = $clog2(SETTLE_CYCLES + 1);
    typedef enum logic [1:0] {SETTLE, IDLE, RUN} state_t;
    state_t           state;
    logic [SW-1:0]    settle;
    logic [CNT_W-1:0] active, pending, cnt, req, next_half;
    logic             ready, tick, sq;
    assign req       = (bus.half_period == '0) ? CNT_W'(1) : bus.half_period;
    assign next_half = bus.load ? req : pending;
    assign bus.ready = ready;
    assign bus.tick  = tick;
    assign bus.sq    = sq;
`ifdef BLINK_TICK_TOGGLE_CNT_EN
    logic [7:0] tog;
    assign bus.toggles = tog;
`else
    assign bus.toggles = 8'h00;
`endif
    // settle hold-off, then down-count the active half-period; reload from pending (or a same-cycle load) at zero
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= SETTLE;
            settle  <= '0;
            active  <= CNT_W'(DEFAULT_HALF);
            pending <= CNT_W'(DEFAULT_HALF);
            cnt     <= '0;
            ready   <= 1'b0;
            tick    <= 1'b0;
            sq      <= 1'b0;
`ifdef BLINK_TICK_TOGGLE_CNT_EN
            tog     <= 8'h00;
`endif
        end else begin
            tick <= 1'b0;
            if (state != SETTLE && bus.load) pending <= req;
            if (state == SETTLE) begin
                if (settle == SW'(SETTLE_CYCLES - 1)) begin
                    state <= IDLE;
                    ready <= 1'b1;
                    cnt   <= active - CNT_W'(1);
                end else begin
                    settle <= settle + SW'(1);
                end
            end else if (state == IDLE) begin
                if (bus.en) state <= RUN;
            end else if (!bus.en) begin
                state <= IDLE;
            end else if (cnt == '0) begin
                sq     <= ~sq;
                tick   <= 1'b1;
                active <= next_half;
                cnt    <= next_half - CNT_W'(1);
`ifdef BLINK_TICK_TOGGLE_CNT_EN
                tog    <= tog + 8'd1;
`endif
            end else begin
                cnt <= cnt - CNT_W'(1);
            end
        end
    end
endmodule
